muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with sign handling, divide-by-zero/overflow fast path and a one-cycle register-file write strobe.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wr_ena
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic [4:0]        rd_reg;
    logic              sign_a;
    logic              sign_b;
    logic [5:0]        count;
    logic [XLEN-1:0]   work;     // multiplier (shifted right) or dividend/quotient (shifted left)
    logic [2*XLEN-1:0] mcand;    // multiplicand shifted left; low half is the divisor for divides
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem;

    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   sel;

    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = signed_a && op_a[XLEN-1];
        neg_b    = signed_b && op_b[XLEN-1];
        mag_a    = neg_a ? (~op_a + 1'b1) : op_a;
        mag_b    = neg_b ? (~op_b + 1'b1) : op_b;
    end

    // One restoring-division step: bring in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted = {rem[XLEN-1:0], work[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand[XLEN-1:0]};
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
        quo_fix  = (sign_a ^ sign_b) ? (~work + 1'b1) : work;
        rem_fix  = sign_a ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
        case (op)
            3'b000:                 sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel = quo_fix;
            default:                sel = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= 3'b000;
            rd_reg <= 5'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            count  <= 6'd0;
            work   <= '0;
            mcand  <= '0;
            prod   <= '0;
            rem    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_ena <= 1'b0;
            result <= '0;
            rd_out <= 5'd0;
        end else begin
            done   <= 1'b0;
            wr_ena <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        op     <= funct3;
                        rd_reg <= rd_in;
                        count  <= 6'd0;
                        prod   <= '0;
                        busy   <= 1'b1;
                        // Special cases carry final values with signs cleared so FIN passes them through.
                        if (funct3[2] && (op_b == '0)) begin
                            work   <= '1;
                            rem    <= {1'b0, op_a};
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            state  <= FIN;
                        end else if (funct3[2] && !funct3[0] &&
                                     (op_a == MIN_INT) && (op_b == '1)) begin
                            work   <= MIN_INT;
                            rem    <= '0;
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            state  <= FIN;
                        end else begin
                            work   <= mag_a;
                            mcand  <= {{XLEN{1'b0}}, mag_b};
                            rem    <= '0;
                            sign_a <= neg_a;
                            sign_b <= neg_b;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (op[2]) begin
                            if (!diff[XLEN+1]) begin
                                rem  <= diff[XLEN:0];
                                work <= {work[XLEN-2:0], 1'b1};
                            end else begin
                                rem  <= shifted;
                                work <= {work[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            prod  <= prod + (work[0] ? mcand : '0);
                            mcand <= {mcand[2*XLEN-2:0], 1'b0};
                            work  <= {1'b0, work[XLEN-1:1]};
                        end
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!kill) begin
                        result <= sel;
                        rd_out <= rd_reg;
                        done   <= 1'b1;
                        wr_ena <= (rd_reg != 5'd0);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
